// File: rtl/nand4_bist_pkg.sv
// nand4_bist_pkg: shared types and constants for the NAND4 BIST controller.
//   state_t   : controller FSM state encoding
//   NUM_PAT   : number of input patterns applied to the cell
//   MISR_SEED : signature register start value
//   MISR_TAPS : XOR feedback taps of the signature register (bits 2..4)
package nand4_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int         NUM_PAT   = 16;
  localparam logic [7:0] MISR_SEED = 8'hFF;
  localparam logic [7:0] MISR_TAPS = 8'h1C;

endpackage

// File: rtl/nand4_bist_if.sv
// nand4_bist_if: handshake and cell-facing signals of the NAND4 BIST controller.
//   start, abort         : run request / run cancel (driven by the requester)
//   zn                   : cell output under test
//   a1..a4               : pattern bits driven into the cell
//   busy, done, pass     : run status
//   err_cnt              : mismatch count, ERR_W bits, saturating
//   first_fail(_vld)     : pattern {a4,a3,a2,a1} of the first mismatch
//   signature            : 8-bit MISR, present only with NAND4_BIST_MISR_EN
// Modports: master = controller side, slave = requester/cell side.
interface nand4_bist_if #(
  parameter int ERR_W = 5
);
  logic             start;
  logic             abort;
  logic             zn;
  logic             a1;
  logic             a2;
  logic             a3;
  logic             a4;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       first_fail;
  logic             first_fail_vld;
`ifdef NAND4_BIST_MISR_EN
  logic [7:0]       signature;

  modport master (
    input  start, abort, zn,
    output a1, a2, a3, a4, busy, done, pass, err_cnt, first_fail, first_fail_vld,
    output signature
  );
  modport slave (
    output start, abort, zn,
    input  a1, a2, a3, a4, busy, done, pass, err_cnt, first_fail, first_fail_vld,
    input  signature
  );
`else
  modport master (
    input  start, abort, zn,
    output a1, a2, a3, a4, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );
  modport slave (
    output start, abort, zn,
    input  a1, a2, a3, a4, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );
`endif
endinterface

// File: rtl/nand4_bist_ctrl_misr.sv
// nand4_bist_misr: 8-bit multiple-input signature register over the sampled ZN stream.
// Only compiled when NAND4_BIST_MISR_EN is defined.
//   CLK   : clock, rising edge
//   RN    : synchronous active-low reset, loads MISR_SEED
//   init  : reload MISR_SEED (run start)
//   shift : absorb din (one SAMPLE cycle)
//   din   : sampled ZN; an X propagates into the signature
//   sig   : current signature
`ifdef NAND4_BIST_MISR_EN
module nand4_bist_misr
  import nand4_bist_pkg::*;
(
  input  logic       CLK,
  input  logic       RN,
  input  logic       init,
  input  logic       shift,
  input  logic       din,
  output logic [7:0] sig
);

  logic fb;
  assign fb = sig[7] ^ din;

  // Shift left with fb entering bit 0; fb is also folded into the tap bits.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      sig <= MISR_SEED;
    end else if (init) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= {sig[6:0], fb} ^ ({8{fb}} & MISR_TAPS);
    end
  end

endmodule
`endif

// File: rtl/nand4_bist_ctrl.sv
// nand4_bist_ctrl: BIST pattern generator and response checker for a 4-input NAND cell.
// Drives all 16 patterns on A1..A4, holds each for SETTLE_CYC cycles, samples ZN and
// compares it (4-state) against ~&pattern. Reports pass/fail, a saturating error count
// and the first failing pattern through a START/DONE handshake.
//   CLK, RN : clock (rising edge) and synchronous active-low reset
//   bus     : nand4_bist_if master modport (start/abort/zn in, pattern and status out)
// Parameters: SETTLE_CYC (1..15), ERR_W (error counter width).
// Optional: NAND4_BIST_MISR_EN adds bus.signature, an 8-bit MISR over the ZN samples.
//
// state  | meaning
// IDLE   | waiting for START; pattern outputs at 0
// APPLY  | pattern P held on A1..A4 for SETTLE_CYC cycles
// SAMPLE | ZN compared against ~&P; advance P or finish
// DONE   | results stable; leaves when START drops
module nand4_bist_ctrl
  import nand4_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 5
) (
  input logic          CLK,
  input logic          RN,
  nand4_bist_if.master bus
);

  localparam logic [3:0] LAST_PAT = 4'(NUM_PAT - 1);
  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYC);

  state_t           state;
  logic [3:0]       pat;
  logic [3:0]       settle;
  logic [3:0]       a_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [3:0]       first_fail_q;
  logic             first_fail_vld_q;

  logic run_start;
  logic do_sample;
  logic mismatch;

  assign run_start = (state == IDLE) && bus.start && !bus.abort;
  // ABORT wins over the sample: an aborted SAMPLE cycle neither counts nor shifts.
  assign do_sample = (state == SAMPLE) && !bus.abort;
  // Case-inequality so an X/Z on ZN is reported as a mismatch.
  assign mismatch  = (bus.zn !== ~&pat);

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state            <= IDLE;
      pat              <= '0;
      settle           <= '0;
      a_q              <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_q <= '0;
          if (run_start) begin
            state            <= APPLY;
            pat              <= '0;
            settle           <= SETTLE;
            busy_q           <= 1'b1;
            err_cnt_q        <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state  <= IDLE;
            a_q    <= '0;
            busy_q <= 1'b0;
          end else if (settle == 4'd1) begin
            state <= SAMPLE;
          end else begin
            settle <= settle - 1'b1;
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            state  <= IDLE;
            a_q    <= '0;
            busy_q <= 1'b0;
          end else begin
            if (mismatch) begin
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
              if (!first_fail_vld_q) begin
                first_fail_q     <= pat;
                first_fail_vld_q <= 1'b1;
              end
            end
            if (pat == LAST_PAT) begin
              state  <= DONE;
              busy_q <= 1'b0;
            end else begin
              state  <= APPLY;
              pat    <= pat + 1'b1;
              a_q    <= pat + 1'b1;
              settle <= SETTLE;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state <= IDLE;
            a_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // DONE/PASS are registered from the state, so they trail entry into DONE by one edge.
      done_q <= (state == DONE);
      pass_q <= (state == DONE) && (err_cnt_q == '0);
    end
  end

  assign bus.a1             = a_q[0];
  assign bus.a2             = a_q[1];
  assign bus.a3             = a_q[2];
  assign bus.a4             = a_q[3];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.first_fail     = first_fail_q;
  assign bus.first_fail_vld = first_fail_vld_q;

`ifdef NAND4_BIST_MISR_EN
  nand4_bist_misr u_misr (
    .CLK   (CLK),
    .RN    (RN),
    .init  (run_start),
    .shift (do_sample),
    .din   (bus.zn),
    .sig   (bus.signature)
  );
`endif

endmodule

// File: tb/tb_nand4_bist_ctrl.sv
// tb_nand4_bist_ctrl: directed bench for nand4_bist_ctrl.
// dut1: SETTLE_CYC=1, ERR_W=5; dut2: same stimulus with ERR_W=3 (saturation);
// dut3: SETTLE_CYC=3 (latency and, with NAND4_BIST_MISR_EN, signature).
module tb_nand4_bist_ctrl;

  typedef struct {
    int         err;
    logic [3:0] ff;
    logic       ffv;
    logic       pass;
  } exp_t;

  logic CLK = 1'b0;
  logic RN;
  logic start, abort, start3;
  int   mode, mode3;
  int   cyc = 0;
  int   k;
  int   errors = 0;
  int   checks = 0;

  exp_t       sb1[$];
  int         sb2[$];
  exp_t       sb3[$];
  logic [7:0] sbsig[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  nand4_bist_if #(.ERR_W(5)) b1 ();
  nand4_bist_if #(.ERR_W(3)) b2 ();
  nand4_bist_if #(.ERR_W(5)) b3 ();

  // Cell model: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 flipped at P=7, 4 X at P=3.
  function automatic logic zn_of(input int m, input logic [3:0] p);
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (p == 4'd7) ? 1'b0 : ~&p;
      4:       return (p == 4'd3) ? 1'bx : ~&p;
      default: return ~&p;
    endcase
  endfunction

  function automatic exp_t model(input int m, input int errmax);
    exp_t e;
    e.err = 0; e.ff = 4'h0; e.ffv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      logic       z;
      p = 4'(i);
      z = zn_of(m, p);
      if (z !== ~&p) begin
        if (e.err < errmax) e.err++;
        if (!e.ffv) begin e.ff = p; e.ffv = 1'b1; end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  function automatic logic [7:0] misr_model(input int m);
    logic [7:0] s, n;
    logic       fb;
    s = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      fb   = s[7] ^ zn_of(m, 4'(i));
      n[0] = fb;
      n[1] = s[0];
      n[2] = s[1] ^ fb;
      n[3] = s[2] ^ fb;
      n[4] = s[3] ^ fb;
      n[5] = s[4];
      n[6] = s[5];
      n[7] = s[6];
      s    = n;
    end
    return s;
  endfunction

  assign b1.start = start;
  assign b1.abort = abort;
  assign b1.zn    = zn_of(mode, {b1.a4, b1.a3, b1.a2, b1.a1});
  assign b2.start = start;
  assign b2.abort = abort;
  assign b2.zn    = zn_of(mode, {b2.a4, b2.a3, b2.a2, b2.a1});
  assign b3.start = start3;
  assign b3.abort = 1'b0;
  assign b3.zn    = zn_of(mode3, {b3.a4, b3.a3, b3.a2, b3.a1});

  nand4_bist_ctrl #(.SETTLE_CYC(1), .ERR_W(5)) dut1 (.CLK(CLK), .RN(RN), .bus(b1.master));
  nand4_bist_ctrl #(.SETTLE_CYC(1), .ERR_W(3)) dut2 (.CLK(CLK), .RN(RN), .bus(b2.master));
  nand4_bist_ctrl #(.SETTLE_CYC(3), .ERR_W(5)) dut3 (.CLK(CLK), .RN(RN), .bus(b3.master));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pat1();
    return {b1.a4, b1.a3, b1.a2, b1.a1};
  endfunction

  task automatic check_reset1(input string tag);
    check({tag, "_a"},    {28'd0, pat1()}, 32'd0);
    check({tag, "_busy"}, {31'd0, b1.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, b1.done}, 32'd0);
    check({tag, "_pass"}, {31'd0, b1.pass}, 32'd0);
    check({tag, "_err"},  {27'd0, b1.err_cnt}, 32'd0);
    check({tag, "_ff"},   {28'd0, b1.first_fail}, 32'd0);
    check({tag, "_ffv"},  {31'd0, b1.first_fail_vld}, 32'd0);
  endtask

  // Raise START at a negedge; k is the cycle count just after the edge that samples it.
  task automatic launch(input int which);
    if (which == 3) start3 = 1'b1; else start = 1'b1;
    @(posedge CLK);
    #1 k = cyc;
  endtask

  task automatic wait_done(input int which, input bit hold, output int lat, output int busyc);
    lat   = -1;
    busyc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (n == 0 && !hold) begin
        if (which == 3) start3 = 1'b0; else start = 1'b0;
      end
      if (which == 3) begin
        busyc += int'(b3.busy);
        if (b3.done) begin lat = cyc - k; break; end
      end else begin
        busyc += int'(b1.busy);
        if (b1.done) begin lat = cyc - k; break; end
      end
    end
  endtask

  task automatic run1(input int m, input bit hold, input string tag);
    exp_t e;
    int   lat, bc;
    mode = m;
    sb1.push_back(model(m, 31));
    sb2.push_back(model(m, 7).err);
    launch(1);
    wait_done(1, hold, lat, bc);
    e = sb1.pop_front();
    check({tag, "_latency"}, lat, 32'd33);
    check({tag, "_busy_cycles"}, bc, 32'd32);
    check({tag, "_err"},  {27'd0, b1.err_cnt}, e.err);
    check({tag, "_pass"}, {31'd0, b1.pass}, {31'd0, e.pass});
    check({tag, "_ffv"},  {31'd0, b1.first_fail_vld}, {31'd0, e.ffv});
    if (e.ffv) check({tag, "_ff"}, {28'd0, b1.first_fail}, {28'd0, e.ff});
    check({tag, "_err_w3"}, {29'd0, b2.err_cnt}, sb2.pop_front());
  endtask

  task automatic run3(input int m, input string tag);
    exp_t       e;
    logic [7:0] sig_exp;
    int         lat, bc;
    mode3 = m;
    sb3.push_back(model(m, 31));
    sbsig.push_back(misr_model(m));
    launch(3);
    wait_done(3, 1'b0, lat, bc);
    e       = sb3.pop_front();
    sig_exp = sbsig.pop_front();
    check({tag, "_latency"}, lat, 32'd65);
    check({tag, "_busy_cycles"}, bc, 32'd64);
    check({tag, "_err"},  {27'd0, b3.err_cnt}, e.err);
    check({tag, "_pass"}, {31'd0, b3.pass}, {31'd0, e.pass});
    if (e.ffv) check({tag, "_ff"}, {28'd0, b3.first_fail}, {28'd0, e.ff});
`ifdef NAND4_BIST_MISR_EN
    check({tag, "_sig"}, {24'd0, b3.signature}, {24'd0, sig_exp});
    if (m != 0)
      check({tag, "_sig_changed"}, {31'd0, b3.signature !== misr_model(0)}, 32'd1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, bcnt;
    RN = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; mode = 0; mode3 = 0;
    repeat (2) @(negedge CLK);
    check_reset1("reset");
`ifdef NAND4_BIST_MISR_EN
    check("reset_sig", {24'd0, b3.signature}, 32'h0000_00FF);
`endif
    RN = 1'b1;
    @(negedge CLK);

    run1(0, 1'b0, "good");
    run1(1, 1'b0, "sa1");
    run1(2, 1'b0, "sa0");
    run1(4, 1'b0, "xzn");

    // Abort during SAMPLE of P=5 on a stuck-at-0 cell, START held high.
    mode = 2;
    launch(1);
    repeat (12) @(negedge CLK);
    check("abort_pre_pat", {28'd0, pat1()}, 32'd5);
    abort = 1'b1;
    @(negedge CLK);
    check("abort_a", {28'd0, pat1()}, 32'd0);
    check("abort_busy", {31'd0, b1.busy}, 32'd0);
    check("abort_err_kept", {31'd0, (b1.err_cnt == 5'd5) || (b1.err_cnt == 5'd6)}, 32'd1);
    check("abort_ffv_kept", {31'd0, b1.first_fail_vld}, 32'd1);
    abort = 1'b0;
    start = 1'b0;
    dcnt  = 0;
    repeat (40) begin @(negedge CLK); dcnt += int'(b1.done); end
    check("abort_no_done", dcnt, 32'd0);
    run1(0, 1'b0, "after_abort");

    // Reset for one edge while P=9 is applied.
    mode = 2;
    launch(1);
    @(negedge CLK);
    start = 1'b0;
    repeat (18) @(negedge CLK);
    check("prereset_pat", {28'd0, pat1()}, 32'd9);
    RN = 1'b0;
    @(negedge CLK);
    check_reset1("midreset");
    RN = 1'b1;
    @(negedge CLK);

    // Good run with START held: DONE persists, no restart until START drops.
    run1(0, 1'b1, "hold");
    dcnt = 0; bcnt = 0;
    repeat (10) begin @(negedge CLK); dcnt += int'(b1.done); bcnt += int'(b1.busy); end
    check("hold_done_cycles", dcnt, 32'd10);
    check("hold_no_restart", bcnt, 32'd0);
    check("hold_a_last", {28'd0, pat1()}, 32'hF);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    check("release_done", {31'd0, b1.done}, 32'd0);
    check("release_busy", {31'd0, b1.busy}, 32'd0);

    run3(0, "s3_good");
    run3(3, "s3_flip7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
